// File: rtl/if_fetch_unit.sv
// Instruction-fetch front end: owns the PC, sequences variable-latency imem
// requests (req/ack), obeys the PCWrite stall and ID-stage redirects, and
// presents the fetched word (or a bubble) to the IF/ID register.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter logic [31:0] BUBBLE_INST = 32'h0400_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        PCWrite,
  input  logic        Redirect,
  input  logic [31:0] Redirect_PC,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] IF_PC,
  output logic [31:0] IF_Inst,
  output logic        IF_Valid
);

  // StDiscard: a redirected request is still outstanding and must be drained
  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StReq     = 2'd1,
    StDiscard = 2'd2,
    StHold    = 2'd3
  } state_e;

  state_e      r_state, w_state_next;
  logic [31:0] r_pc, w_pc_next;
  logic [31:0] r_req_addr, w_req_addr_next;
  logic [31:0] r_buf_inst, w_buf_inst_next;
  logic [31:0] r_buf_pc, w_buf_pc_next;
  logic [31:0] w_redir_pc;
  logic [31:0] w_seq_pc;

  assign w_redir_pc = {Redirect_PC[31:2], 2'b00};
  // Wraps naturally modulo 2^32
  assign w_seq_pc   = r_buf_pc + 32'd4;

  // State and datapath registers; reset abandons any outstanding request
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= StIdle;
      r_pc       <= RESET_PC;
      r_req_addr <= RESET_PC;
      r_buf_inst <= BUBBLE_INST;
      r_buf_pc   <= 32'h0;
    end else begin
      r_state    <= w_state_next;
      r_pc       <= w_pc_next;
      r_req_addr <= w_req_addr_next;
      r_buf_inst <= w_buf_inst_next;
      r_buf_pc   <= w_buf_pc_next;
    end
  end

  // Next-state logic; Redirect always beats PCWrite. req_addr latches the
  // post-edge pc on every entry into StReq.
  always_comb begin
    w_state_next    = r_state;
    w_pc_next       = r_pc;
    w_req_addr_next = r_req_addr;
    w_buf_inst_next = r_buf_inst;
    w_buf_pc_next   = r_buf_pc;
    unique case (r_state)
      StIdle: begin
        if (Redirect) w_pc_next = w_redir_pc;
        w_state_next    = StReq;
        w_req_addr_next = w_pc_next;
      end
      StReq: begin
        if (imem_ack) begin
          if (Redirect) begin
            w_pc_next       = w_redir_pc;
            w_req_addr_next = w_redir_pc;
            w_state_next    = StReq;
          end else begin
            w_buf_inst_next = imem_rdata;
            w_buf_pc_next   = r_req_addr;
            w_state_next    = StHold;
          end
        end else if (Redirect) begin
          // Request cannot be withdrawn; drain it and drop the data
          w_pc_next    = w_redir_pc;
          w_state_next = StDiscard;
        end
      end
      StDiscard: begin
        if (Redirect) w_pc_next = w_redir_pc;
        if (imem_ack) begin
          w_state_next    = StReq;
          w_req_addr_next = w_pc_next;
        end
      end
      StHold: begin
        if (Redirect) begin
          w_pc_next       = w_redir_pc;
          w_state_next    = StReq;
          w_req_addr_next = w_redir_pc;
        end else if (PCWrite) begin
          w_pc_next       = w_seq_pc;
          w_state_next    = StReq;
          w_req_addr_next = w_seq_pc;
        end
      end
      default: w_state_next = StIdle;
    endcase
  end

  // Outputs decoded from state only, so reset takes effect asynchronously
  always_comb begin
    imem_req  = (r_state == StReq) || (r_state == StDiscard);
    imem_addr = r_req_addr;
    IF_Valid  = (r_state == StHold);
    IF_Inst   = IF_Valid ? r_buf_inst : BUBBLE_INST;
    IF_PC     = IF_Valid ? w_seq_pc : 32'h0;
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Self-checking bench for if_fetch_unit: random-latency memory, random
// stalls/redirects, and a transaction-level model of the expected fetch stream.
module tb_if_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] BUBBLE   = 32'h0400_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        PCWrite, Redirect, imem_ack;
  logic [31:0] Redirect_PC;
  logic        imem_req;
  logic [31:0] imem_addr, imem_rdata;
  logic [31:0] IF_PC, IF_Inst;
  logic        IF_Valid;

  if_fetch_unit #(
    .RESET_PC   (RESET_PC),
    .BUBBLE_INST(BUBBLE)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .PCWrite    (PCWrite),
    .Redirect   (Redirect),
    .Redirect_PC(Redirect_PC),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .IF_PC      (IF_PC),
    .IF_Inst    (IF_Inst),
    .IF_Valid   (IF_Valid)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Memory contents: a fixed scramble of the address
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC001_D00D;
  endfunction

  assign imem_rdata = imem_req ? mem_word(imem_addr) : 32'hDEAD_BEEF;

  // Reference model of the fetch stream, as seen at the interface
  logic        m_req;        // a request is expected to be visible
  logic [31:0] m_req_addr;   // its address
  logic        m_live;       // its data will be delivered (no redirect since issue)
  logic        m_valid;      // an instruction is expected to be held
  logic [31:0] m_hold_addr;  // address of the held instruction
  logic [31:0] m_next_pc;    // where the next fetch goes

  // Memory responder and stimulus knobs
  logic        mem_busy;
  int          mem_wait;
  int          p_redir, p_pcw, w_lo, w_hi;
  logic        force_redir;
  logic [31:0] force_rpc;

  task automatic model_reset();
    m_req       = 1'b0;
    m_valid     = 1'b0;
    m_live      = 1'b0;
    m_req_addr  = RESET_PC;
    m_hold_addr = 32'h0;
    m_next_pc   = RESET_PC;
    mem_busy    = 1'b0;
    mem_wait    = 0;
  endtask

  function automatic logic [31:0] pick_rpc();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 3))
      0:       return r & 32'h0000_0FFF;
      1:       return 32'hFFFF_FFF0 | (r & 32'hF);
      2:       return r;
      default: return r & 32'h0000_03FF;
    endcase
  endfunction

  // One cycle: check outputs, drive inputs, advance model, wait for next negedge
  task automatic do_cycle();
    logic        redir, pcw, ack;
    logic [31:0] rpc, rpc_al;
    check_eq("imem_req", 32'(imem_req), 32'(m_req));
    if (m_req) check_eq("imem_addr", imem_addr, m_req_addr);
    check_eq("IF_Valid", 32'(IF_Valid), 32'(m_valid));
    if (m_valid) begin
      check_eq("IF_PC", IF_PC, m_hold_addr + 32'd4);
      check_eq("IF_Inst", IF_Inst, mem_word(m_hold_addr));
    end else begin
      check_eq("IF_Inst_bubble", IF_Inst, BUBBLE);
    end

    redir       = force_redir || (int'($urandom_range(0, 99)) < p_redir);
    rpc         = force_redir ? force_rpc : pick_rpc();
    force_redir = 1'b0;
    pcw         = int'($urandom_range(0, 99)) < p_pcw;
    ack         = 1'b0;
    if (imem_req) begin
      if (!mem_busy) begin
        mem_busy = 1'b1;
        mem_wait = int'($urandom_range(w_lo, w_hi));
      end
      if (mem_wait == 0) begin
        ack      = 1'b1;
        mem_busy = 1'b0;
      end else begin
        mem_wait--;
      end
    end
    Redirect    = redir;
    Redirect_PC = rpc;
    PCWrite     = pcw;
    imem_ack    = ack;

    rpc_al = {rpc[31:2], 2'b00};
    if (m_req) begin
      if (ack) begin
        if (m_live && !redir) begin
          m_req       = 1'b0;
          m_valid     = 1'b1;
          m_hold_addr = m_req_addr;
        end else begin
          if (redir) m_next_pc = rpc_al;
          m_req_addr = m_next_pc;
          m_live     = 1'b1;
        end
      end else if (redir) begin
        m_live    = 1'b0;
        m_next_pc = rpc_al;
      end
    end else if (m_valid) begin
      if (redir || pcw) begin
        m_next_pc  = redir ? rpc_al : m_hold_addr + 32'd4;
        m_valid    = 1'b0;
        m_req      = 1'b1;
        m_req_addr = m_next_pc;
        m_live     = 1'b1;
      end
    end else begin
      if (redir) m_next_pc = rpc_al;
      m_req      = 1'b1;
      m_req_addr = m_next_pc;
      m_live     = 1'b1;
    end
    @(negedge clk);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) do_cycle();
  endtask

  task automatic knobs(input int pr, input int pw, input int lo, input int hi);
    p_redir = pr;
    p_pcw   = pw;
    w_lo    = lo;
    w_hi    = hi;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_req"}, 32'(imem_req), 32'h0);
    check_eq({tag, "_valid"}, 32'(IF_Valid), 32'h0);
    check_eq({tag, "_inst"}, IF_Inst, BUBBLE);
    check_eq({tag, "_pc"}, IF_PC, 32'h0);
  endtask

  // Assert reset between clock edges and check it acts without a clock
  task automatic async_reset();
    @(posedge clk);
    #2 rst = 1'b1;
    #1 check_reset_outputs("async_rst");
    @(negedge clk);
    Redirect = 1'b0;
    PCWrite  = 1'b0;
    imem_ack = 1'b0;
    rst      = 1'b0;
    model_reset();
  endtask

  initial begin
    rst         = 1'b0;
    PCWrite     = 1'b0;
    Redirect    = 1'b0;
    Redirect_PC = 32'h0;
    imem_ack    = 1'b0;
    force_redir = 1'b0;
    force_rpc   = 32'h0;
    knobs(0, 100, 0, 0);
    model_reset();
    #1 rst = 1'b1;
    #2 check_reset_outputs("por");
    @(negedge clk);
    rst = 1'b0;

    // Zero-wait sequential fetch
    knobs(0, 100, 0, 0);
    run(10);
    // Three-wait fetch at 0x40
    knobs(0, 100, 3, 3);
    force_redir = 1'b1;
    force_rpc   = 32'h40;
    run(16);
    // Long stall in hold
    knobs(0, 0, 1, 1);
    run(8);
    knobs(0, 100, 1, 1);
    run(6);
    // Redirect during a multi-wait request
    knobs(0, 100, 2, 2);
    force_redir = 1'b1;
    force_rpc   = 32'h20;
    run(2);
    force_redir = 1'b1;
    force_rpc   = 32'h100;
    run(12);
    // Unaligned redirect target, redirect together with PCWrite
    knobs(0, 100, 0, 0);
    force_redir = 1'b1;
    force_rpc   = 32'h203;
    run(6);
    // Reset during drain, then fetch across the address wrap
    knobs(40, 100, 3, 3);
    run(5);
    async_reset();
    knobs(0, 100, 0, 0);
    force_redir = 1'b1;
    force_rpc   = 32'hFFFF_FFFC;
    run(10);
    // Random traffic with periodic resets
    for (int r = 0; r < 4; r++) begin
      knobs(15, 60, 0, 3);
      run(600);
      async_reset();
    end
    run(4);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
